// File: rtl/crossing_scheduler.sv
// -----------------------------------------------------------------------------
// crossing_scheduler
//   Mid-block pedestrian crossing controller. One car signal is shared by two
//   crosswalks (A and B). A pedestrian request ends the car-green phase once
//   the minimum green time has passed. The controller then steps through
//   YELLOW, RED1, WALK, FLASH and RED2, and returns to GREEN. Each WALK serves
//   exactly one crosswalk. When both crosswalks are waiting, a round-robin
//   pointer decides which one is served.
//
//   All timing counts 'tick' pulses (one per second). The inputs are sampled
//   on every clock. The state only changes on a tick cycle.
//
//   Optional feature: define EMERGENCY_PREEMPT_EN to enable emergency-vehicle
//   preemption. Without it, the emergency port is present but has no effect.
//
// Ports
//   clock      : single clock
//   reset      : asynchronous, active-high
//   tick       : one-cycle enable pulse, once per second
//   ped_req_a  : crosswalk A button (level or pulse)
//   ped_req_b  : crosswalk B button (level or pulse)
//   emergency  : emergency-vehicle preempt request
//   car_green, car_yellow, car_red : car signal lamps
//   walk_a, walk_b : walk lamps; only the crosswalk being served is lit
//   flash      : flashing don't-walk, high in FLASH
//   ack_a/ack_b: one-cycle pulse when service of A/B starts
//   state      : current FSM state encoding
// -----------------------------------------------------------------------------
module crossing_scheduler #(
  parameter int unsigned T_MIN_GREEN = 8,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 5,
  parameter int unsigned T_FLASH     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic       emergency,
  output logic       car_green,
  output logic       car_yellow,
  output logic       car_red,
  output logic       walk_a,
  output logic       walk_b,
  output logic       flash,
  output logic       ack_a,
  output logic       ack_b,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_RED1   = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4,
    S_RED2   = 3'd5
  } state_t;

  state_t     cur, nxt;
  logic [3:0] timer, timer_nxt;
  logic       pend_a, pend_b;
  logic       rr_ptr;      // 0: A has priority next time both wait, 1: B
  logic       served;      // crosswalk served in the current WALK: 0=A, 1=B
  logic       served_nxt;
  logic       serve_a, serve_b;
  logic       timer_zero;
  logic       emg;

`ifdef EMERGENCY_PREEMPT_EN
  assign emg = emergency;
`else
  assign emg = 1'b0;
  logic unused_emergency;
  assign unused_emergency = emergency;
`endif

  assign timer_zero = (timer == 4'd0);

  // Timer reload value: the state lasts exactly its duration in ticks,
  // because the timer leaves it on the tick where the count is already 0.
  function automatic logic [3:0] dur_m1(input state_t s);
    case (s)
      S_GREEN:  return 4'(T_MIN_GREEN - 1);
      S_YELLOW: return 4'(T_YELLOW - 1);
      S_WALK:   return 4'(T_WALK - 1);
      S_FLASH:  return 4'(T_FLASH - 1);
      default:  return 4'(T_ALLRED - 1);   // RED1 and RED2
    endcase
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    nxt        = cur;
    timer_nxt  = timer;
    serve_a    = 1'b0;
    serve_b    = 1'b0;
    served_nxt = served;

    if (tick) begin
      case (cur)
        S_GREEN:  if (timer_zero && (pend_a || pend_b) && !emg) nxt = S_YELLOW;
        S_YELLOW: if (timer_zero) nxt = S_RED1;
        S_RED1:   if (timer_zero) nxt = emg ? S_RED2 : S_WALK;
        S_WALK:   if (timer_zero || emg) nxt = S_FLASH;
        S_FLASH:  if (timer_zero) nxt = S_RED2;
        S_RED2:   if (timer_zero) nxt = S_GREEN;
        default:  nxt = S_GREEN;
      endcase

      // On a state change the timer is reloaded. Otherwise it counts down
      // and stays at 0 while GREEN waits for a request.
      if (nxt != cur)      timer_nxt = dur_m1(nxt);
      else if (!timer_zero) timer_nxt = timer - 4'd1;
    end

    // Choose the crosswalk to serve on the cycle that enters WALK.
    if (nxt == S_WALK && cur != S_WALK) begin
      if (pend_a && (!pend_b || !rr_ptr)) begin
        serve_a    = 1'b1;
        served_nxt = 1'b0;
      end else if (pend_b) begin
        serve_b    = 1'b1;
        served_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= S_GREEN;
      timer      <= dur_m1(S_GREEN);
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      rr_ptr     <= 1'b0;
      served     <= 1'b0;
      car_green  <= 1'b1;
      car_yellow <= 1'b0;
      car_red    <= 1'b0;
      walk_a     <= 1'b0;
      walk_b     <= 1'b0;
      flash      <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      state      <= S_GREEN;
    end else begin
      cur    <= nxt;
      timer  <= timer_nxt;
      served <= served_nxt;

      // A press in the same cycle as the clear wins, so the bit stays set.
      pend_a <= ped_req_a | (pend_a & ~serve_a);
      pend_b <= ped_req_b | (pend_b & ~serve_b);

      // The pointer always moves away from the crosswalk just served.
      if (serve_a) rr_ptr <= 1'b1;
      if (serve_b) rr_ptr <= 1'b0;

      // The outputs are decoded from the next state, so the registered lamps
      // change on the same edge as the state.
      car_green  <= (nxt == S_GREEN);
      car_yellow <= (nxt == S_YELLOW);
      car_red    <= (nxt inside {S_RED1, S_WALK, S_FLASH, S_RED2});
      walk_a     <= (nxt == S_WALK) && !served_nxt;
      walk_b     <= (nxt == S_WALK) &&  served_nxt;
      flash      <= (nxt == S_FLASH);
      ack_a      <= serve_a;
      ack_b      <= serve_b;
      state      <= nxt;
    end
  end

endmodule

// File: tb/tb_crossing_scheduler.sv
// -----------------------------------------------------------------------------
// tb_crossing_scheduler
//   Self-checking bench for crossing_scheduler. A behavioural model follows
//   the phase sequence. It counts the ticks spent in each phase against a
//   table of durations, and it keeps the two pending requests and the
//   round-robin choice. All DUT outputs are compared with the model after
//   every clock. Directed scenarios check the timing of the key phases
//   against fixed values.
// -----------------------------------------------------------------------------
module tb_crossing_scheduler;

  localparam int T_MIN_GREEN = 8;
  localparam int T_YELLOW    = 3;
  localparam int T_ALLRED    = 1;
  localparam int T_WALK      = 5;
  localparam int T_FLASH     = 3;

  localparam int GREEN = 0, YELLOW = 1, RED1 = 2, WALK = 3, FLASH = 4, RED2 = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, ped_req_a = 1'b0, ped_req_b = 1'b0, emergency = 1'b0;
  logic car_green, car_yellow, car_red, walk_a, walk_b, flash, ack_a, ack_b;
  logic [2:0] state;

  crossing_scheduler #(
    .T_MIN_GREEN(T_MIN_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED),
    .T_WALK(T_WALK), .T_FLASH(T_FLASH)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .ped_req_a(ped_req_a), .ped_req_b(ped_req_b), .emergency(emergency),
    .car_green(car_green), .car_yellow(car_yellow), .car_red(car_red),
    .walk_a(walk_a), .walk_b(walk_b), .flash(flash),
    .ack_a(ack_a), .ack_b(ack_b), .state(state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int dur[6] = '{T_MIN_GREEN, T_YELLOW, T_ALLRED, T_WALK, T_FLASH, T_ALLRED};
  int m_phase;        // current phase
  int m_ticks;        // ticks spent in the current phase (saturates)
  bit m_wait_a, m_wait_b;
  bit m_next_b;       // 1: B wins the next tie
  bit m_serving_b;
  bit m_ack_a, m_ack_b;

  task automatic model_reset();
    m_phase = GREEN; m_ticks = 0;
    m_wait_a = 0; m_wait_b = 0; m_next_b = 0; m_serving_b = 0;
    m_ack_a = 0; m_ack_b = 0;
  endtask

  task automatic model_clock(input bit t, input bit ra, input bit rb, input bit em);
    int  np;
    bit  emg, done, clr_a, clr_b;
`ifdef EMERGENCY_PREEMPT_EN
    emg = em;
`else
    emg = 1'b0;
`endif
    np = m_phase; clr_a = 0; clr_b = 0;
    if (t) begin
      if (m_ticks < dur[m_phase]) m_ticks++;
      done = (m_ticks >= dur[m_phase]);
      case (m_phase)
        GREEN:  if (done && (m_wait_a || m_wait_b) && !emg) np = YELLOW;
        YELLOW: if (done) np = RED1;
        RED1:   if (done) np = emg ? RED2 : WALK;
        WALK:   if (done || emg) np = FLASH;
        FLASH:  if (done) np = RED2;
        default: if (done) np = GREEN;
      endcase
    end
    if (np != m_phase) m_ticks = 0;
    if (np == WALK && m_phase != WALK) begin
      if (m_wait_a && m_wait_b) begin
        if (m_next_b) clr_b = 1; else clr_a = 1;
      end else if (m_wait_a) clr_a = 1;
      else if (m_wait_b) clr_b = 1;
      if (clr_a) begin m_serving_b = 0; m_next_b = 1; end
      if (clr_b) begin m_serving_b = 1; m_next_b = 0; end
    end
    m_ack_a = clr_a; m_ack_b = clr_b;
    m_wait_a = ra || (m_wait_a && !clr_a);
    m_wait_b = rb || (m_wait_b && !clr_b);
    m_phase = np;
  endtask

  function automatic logic [10:0] model_outs();
    return {3'(m_phase), m_phase == GREEN, m_phase == YELLOW,
            m_phase inside {RED1, WALK, FLASH, RED2},
            m_phase == WALK && !m_serving_b, m_phase == WALK && m_serving_b,
            m_phase == FLASH, m_ack_a, m_ack_b};
  endfunction

  function automatic logic [10:0] dut_outs();
    return {state, car_green, car_yellow, car_red, walk_a, walk_b, flash, ack_a, ack_b};
  endfunction

  // ---------------- stimulus helpers ----------------
  int tick_no, cnt_ack_a, cnt_ack_b, ack_a_tick, ack_b_tick;

  task automatic compare_all(input string tag);
    check(tag, 32'(dut_outs()), 32'(model_outs()));
    check("one_car_lamp", 32'($countones({car_green, car_yellow, car_red})), 32'd1);
  endtask

  // The inputs are applied just after an edge. The model then evaluates the
  // coming edge, and the outputs are sampled 1 time unit after that edge.
  task automatic step(input bit t, input bit ra, input bit rb, input bit em);
    tick = t; ped_req_a = ra; ped_req_b = rb; emergency = em;
    model_clock(t, ra, rb, em);
    @(posedge clock); #1;
    if (t) tick_no++;
    if (ack_a) begin cnt_ack_a++; ack_a_tick = tick_no; end
    if (ack_b) begin cnt_ack_b++; ack_b_tick = tick_no; end
    compare_all("outs");
  endtask

  task automatic tick_cyc(input bit ra, input bit rb, input bit em);
    step(1, ra, rb, em);
    step(0, ra, rb, em);
  endtask

  // Asynchronous reset: the outputs must change before any clock edge.
  task automatic do_reset();
    tick = 0; ped_req_a = 0; ped_req_b = 0; emergency = 0;
    reset = 1;
    model_reset();
    #1;
    compare_all("reset_async");
    @(posedge clock); #1;
    reset = 0;
    tick_no = 0; cnt_ack_a = 0; cnt_ack_b = 0; ack_a_tick = -1; ack_b_tick = -1;
  endtask

  function automatic int req020_state(input int n);
    case (n)
      7: return GREEN;   8: return YELLOW;  10: return YELLOW;
      11: return RED1;   12: return WALK;   16: return WALK;
      17: return FLASH;  20: return RED2;   21: return GREEN;
      default: return -1;
    endcase
  endfunction

  bit em_rand;

  initial begin
    @(posedge clock); #1;
    do_reset();

    // Idle: GREEN is held for 50 ticks.
    for (int i = 0; i < 50; i++) tick_cyc(0, 0, 0);
    check("idle_state", 32'(state), 32'(GREEN));
    check("idle_green", 32'(car_green), 32'd1);

    // A single press on crosswalk A after tick 2.
    do_reset();
    tick_cyc(0, 0, 0); tick_cyc(0, 0, 0);
    step(0, 1, 0, 0);
    for (int n = 3; n <= 21; n++) begin
      tick_cyc(0, 0, 0);
      if (req020_state(n) >= 0) check($sformatf("req020_t%0d", n), 32'(state), 32'(req020_state(n)));
      if (n == 12) check("req020_walk_a", 32'(walk_a), 32'd1);
    end
    check("req020_ack_tick", 32'(ack_a_tick), 32'd12);

    // Both crosswalks press together: A first, B one full cycle later.
    do_reset();
    step(0, 1, 1, 0);
    for (int n = 1; n <= 40; n++) tick_cyc(0, 0, 0);
    check("req021_ack_a_tick", 32'(ack_a_tick), 32'd12);
    check("req021_ack_b_tick", 32'(ack_b_tick), 32'd33);
    check("req021_counts", 32'({cnt_ack_a[7:0], cnt_ack_b[7:0]}), 32'h0101);

    // A held high across WALK entry: the request survives its own clear.
    do_reset();
    step(0, 1, 0, 0);
    for (int n = 1; n <= 11; n++) tick_cyc(0, 0, 0);
    tick_cyc(1, 0, 0); tick_cyc(1, 0, 0);
    for (int n = 14; n <= 40; n++) tick_cyc(0, 0, 0);
    check("req022_ack_a_count", 32'(cnt_ack_a), 32'd2);
    check("req022_second_tick", 32'(ack_a_tick), 32'd33);

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency in WALK cuts it short, then GREEN holds despite pending B.
    do_reset();
    step(0, 0, 1, 0);
    for (int n = 1; n <= 13; n++) tick_cyc(0, 0, 0);
    tick_cyc(0, 0, 1);
    check("emg_flash", 32'(state), 32'(FLASH));
    for (int n = 15; n <= 18; n++) tick_cyc(0, 0, 1);
    check("emg_green", 32'(state), 32'(GREEN));
    step(0, 0, 1, 1);
    for (int n = 19; n <= 38; n++) tick_cyc(0, 0, 1);
    check("emg_hold", 32'(state), 32'(GREEN));
    for (int n = 0; n < 12; n++) tick_cyc(0, 0, 0);
`endif

    // Reset during FLASH drops the sequence and the pending requests.
    do_reset();
    step(0, 1, 0, 0);
    for (int n = 1; n <= 17; n++) tick_cyc(0, 0, 0);
    check("req024_in_flash", 32'(state), 32'(FLASH));
    step(0, 0, 1, 0);
    do_reset();
    check("req024_flash_off", 32'(flash), 32'd0);
    for (int n = 0; n < 30; n++) tick_cyc(0, 0, 0);
    check("req024_pend_lost", 32'(state), 32'(GREEN));

    // Randomised traffic with occasional emergency and reset.
    do_reset();
    em_rand = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) em_rand = !em_rand;
      if ($urandom_range(999) == 0) begin
        do_reset();
        em_rand = 0;
      end else begin
        step($urandom_range(3) == 0, $urandom_range(39) == 0,
             $urandom_range(39) == 0, em_rand);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
